// File: rtl/pulse_sched.sv
// Jittered pulse-train scheduler: draws one Gaussian sample per pulse to randomise the
// rising-edge spacing around a programmed mean, with continuous and one-shot modes.
//   state | meaning
//   IDLE  | no pulse scheduled
//   LOAD  | sample config and gr, compute clamped interval
//   WAIT  | down-count to the pulse start
//   FIRE  | pulse high for pwe cycles
module pulse_sched #(
   parameter int CNT_W = 24,
   parameter int PW_W  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [11:0]      gr,
   input  logic             en,
   input  logic             single,
   input  logic [CNT_W-1:0] period,
   input  logic [3:0]       jit_shift,
   input  logic [PW_W-1:0]  pw,
   output logic             pulse,
   output logic             busy,
   output logic             clip,
   output logic [15:0]      pulse_cnt
);

   localparam int W2 = CNT_W + 2;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_FIRE} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [PW_W-1:0]   pwe_q, pwe_d;
   logic              oneshot_q, oneshot_d;
   logic              pulse_q, pulse_d;
   logic              busy_q, busy_d;
   logic              clip_q, clip_d;
   logic [15:0]       pulse_cnt_q, pulse_cnt_d;

   logic [PW_W-1:0]   pwe_in;
   logic signed [12:0] off, jit;
   logic signed [W2-1:0] ival_raw, ival_lo, ival_hi, ival_cl, wait_len;
   logic              clamp;

   // Interval arithmetic, only consumed while in LOAD
   always_comb begin
      pwe_in   = (pw == '0) ? PW_W'(1) : pw;
      off      = $signed({1'b0, gr}) - 13'sh800;
      jit      = (jit_shift >= 4'd12) ? 13'sd0 : (off >>> jit_shift);
      ival_raw = $signed({2'b00, period}) + $signed({{(W2-13){jit[12]}}, jit});
      ival_lo  = $signed({{(W2-PW_W){1'b0}}, pwe_in}) + $signed(W2'(2));
      ival_hi  = $signed({2'b00, {CNT_W{1'b1}}});
      clamp    = 1'b0;
      ival_cl  = ival_raw;
      if (ival_raw < ival_lo) begin
         ival_cl = ival_lo;
         clamp   = 1'b1;
      end else if (ival_raw > ival_hi) begin
         ival_cl = ival_hi;
         clamp   = 1'b1;
      end
      // ival - pwe - 1 == ival - (pwe + 2) + 1, never below 1
      wait_len = ival_cl - ival_lo + $signed(W2'(1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         pwe_q       <= '0;
         oneshot_q   <= 1'b0;
         pulse_q     <= 1'b0;
         busy_q      <= 1'b0;
         clip_q      <= 1'b0;
         pulse_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pwe_q       <= pwe_d;
         oneshot_q   <= oneshot_d;
         pulse_q     <= pulse_d;
         busy_q      <= busy_d;
         clip_q      <= clip_d;
         pulse_cnt_q <= pulse_cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pwe_d     = pwe_q;
      oneshot_d = oneshot_q;
      case (state_q)
         S_IDLE: begin
            if (en) begin
               state_d = S_LOAD;
            end else if (single) begin
               state_d   = S_LOAD;
               oneshot_d = 1'b1;
            end
         end
         S_LOAD: begin
            state_d = S_WAIT;
            cnt_d   = wait_len[CNT_W-1:0];
            pwe_d   = pwe_in;
         end
         S_WAIT: begin
            if (!oneshot_q && !en) begin
               state_d = S_IDLE;
            end else if (cnt_q == CNT_W'(1)) begin
               state_d = S_FIRE;
               cnt_d   = {{(CNT_W-PW_W){1'b0}}, pwe_q};
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_FIRE: begin
            if (cnt_q == CNT_W'(1)) begin
               if (oneshot_q) begin
                  state_d   = S_IDLE;
                  oneshot_d = 1'b0;
               end else if (en) begin
                  state_d = S_LOAD;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      pulse_d     = (state_d == S_FIRE);
      busy_d      = (state_d != S_IDLE);
      clip_d      = (state_q == S_LOAD) && clamp;
      pulse_cnt_d = pulse_cnt_q;
      if (state_q == S_WAIT && state_d == S_FIRE) begin
         pulse_cnt_d = pulse_cnt_q + 16'd1;
      end
   end

   assign pulse     = pulse_q;
   assign busy      = busy_q;
   assign clip      = clip_q;
   assign pulse_cnt = pulse_cnt_q;

endmodule

// File: doc/pulse_sched.md
# pulse_sched

Jittered pulse-train scheduler for the DE0 pulse generator. It consumes the free-running 12-bit Gaussian sample stream from `gaus_rand` and draws one sample per pulse. It uses that sample to randomise the pulse-to-pulse interval around a programmed mean, and drives a fixed-width output pulse. It supports continuous and one-shot modes and sits between the register/config logic and the output driver.

## Interface
- `CNT_W`, default 24: width of the period and interval arithmetic.
- `PW_W`, default 8: width of the pulse-width setting.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset, synchronous, active-high.
- `gr`  in  12  Gaussian sample, unsigned, centred at 0x800; valid every cycle.
- `en`  in  1  continuous-mode enable, level.
- `single`  in  1  one-cycle strobe; requests exactly one pulse.
- `period`  in  CNT_W  mean rising-edge spacing, in cycles.
- `jit_shift`  in  4  jitter attenuation (right shift).
- `pw`  in  PW_W  pulse width in cycles; a value of 0 is treated as 1.
- `pulse`  out  1  output pulse, registered.
- `busy`  out  1  high whenever the state is not IDLE.
- `clip`  out  1  one-cycle strobe; the interval was clamped.
- `pulse_cnt`  out  16  pulses issued; wraps from 0xFFFF to 0.

## Operation
- States: IDLE, LOAD, WAIT, FIRE.
- IDLE:
  - `en`=1 → LOAD, continuous mode.
  - Otherwise, `single`=1 → LOAD, with the `oneshot` flag set.
  - `en` has priority when both are high.
- LOAD (exactly 1 cycle): sample `gr`, `period`, `jit_shift` and `pw`; the sampled values are held until the next LOAD.
  - `off` = `gr` − 0x800, 13-bit signed, range −2048..+2047.
  - `jit` = `off` >>> `jit_shift` (arithmetic shift); `jit` is forced to 0 when `jit_shift` ≥ 12.
  - `ival` = `period` + `jit`, computed at CNT_W+2 bits signed.
  - Clamp `ival` to the range [`pwe`+2, 2^CNT_W−1], where `pwe` = max(`pw`,1). If the clamp is applied, `clip`=1 in the next cycle.
  - Load the wait counter with `ival` − `pwe` − 1, which is always ≥ 1. Go to WAIT.
- WAIT: decrement the counter each cycle.
  - `en`=0 in continuous mode → IDLE next cycle; no pulse is issued.
  - After the last WAIT cycle → FIRE.
- FIRE: `pulse`=1 for exactly `pwe` cycles. `pulse_cnt` increments once, in the first FIRE cycle. At the end of FIRE:
  - `oneshot` set → IDLE, and `oneshot` clears.
  - `en`=1 → LOAD.
  - Otherwise → IDLE.
- Dropping `en` during FIRE never truncates the pulse.
- A one-shot ignores `en` until it completes.
- `single` outside IDLE is ignored; it is not queued.
- Config input changes outside LOAD have no effect until the next LOAD.
- Reset values: state=IDLE, `pulse`=0, `busy`=0, `clip`=0, `pulse_cnt`=0, counters=0, `oneshot`=0. Only `rst` clears `pulse_cnt`.

## Timing
- One cycle per pulse spent in LOAD, (`ival` − `pwe` − 1) in WAIT and `pwe` in FIRE. Continuous-mode rising-edge spacing therefore equals `ival` exactly.
- With `gr`=0x800 and no clamp, the spacing is `period`.
- `en` or `single` sampled high in IDLE at edge n: LOAD during cycle n+1; first `pulse`-high cycle is n+1+`ival`−`pwe`.
- `busy` rises with LOAD, and falls in the first cycle that IDLE is re-entered.
- `rst` asserted in any state: all outputs hold their reset values from the next edge; there is no partial pulse.
- `pulse_cnt` at 0xFFFF increments to 0x0000. No flag is raised.

## Test plan
- **Nominal continuous pulsing:** `gr`=0x800, `period`=100, `pw`=10, `en`=1. Required: `pulse` high for 10 cycles, rising edges exactly 100 cycles apart, `pulse_cnt`=5 after 5 pulses, `clip` never set.
- **Jitter extremes:** `period`=1000, `jit_shift`=4.
  - `gr`=0x000 → spacing 872.
  - `gr`=0xFFF → spacing 1127.
  - `jit_shift`=12 → spacing 1000 for any `gr`.
- **Clamp:** `period`=5, `pw`=10, `gr`=0x800. Required: spacing 12 with a 10-cycle pulse, and `clip` strobes once per LOAD.
- **One-shot:** `en`=0, `single` strobed at edge n with `period`=50, `pw`=5, `gr`=0x800. Required:
  - `busy` high from n+1 through n+50.
  - `pulse` high from n+46 through n+50.
  - Exactly one pulse; a second `single` strobe at n+20 is ignored.
- **Abort:** with `en` running, drop `en` mid-WAIT → no further pulse and `busy`=0 on the next cycle. Drop `en` on the 2nd FIRE cycle of a `pw`=10 pulse → `pulse` stays high for the full 10 cycles, then IDLE.
- **Reset mid-FIRE:** assert `rst` while `pulse`=1 and `pulse_cnt`=3. Required: next cycle `pulse`=0, `busy`=0 and `pulse_cnt`=0; normal operation resumes after `rst` deasserts with `en`=1.
